// File: rtl/data_mem_responder_if.sv
// Data-memory bus between a load/store requester (master) and the
// data_mem_responder (slave).
//
// Handshake: the master raises busReq with busWe/busFunc3/busAddr/busWData
// stable and keeps busReq high until it sees busReady. busReady is a
// one-cycle completion pulse. busRData and busErr are valid in that cycle,
// and busRData holds its value until the next load completes. If busReq is
// still high in the cycle after busReady, that is a new request.
interface data_mem_responder_if;
  logic        busReq;
  logic        busWe;
  logic [2:0]  busFunc3;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [31:0] busRData;
  logic        busReady;
  logic        busErr;

  modport master (
    output busReq, busWe, busFunc3, busAddr, busWData,
    input  busRData, busReady, busErr
  );

  modport slave (
    input  busReq, busWe, busFunc3, busAddr, busWData,
    output busRData, busReady, busErr
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: a word-organised data memory behind a request/ready
// bus. It serves RV32I byte, half and word loads and stores, and it adds
// WAIT_CYCLES wait states to each access.
// Optional feature macro: BUS_MISALIGN_ERR_EN. When it is defined, a
// misaligned half or word access raises busErr, the store is dropped, and
// the load returns 0. When it is undefined, the address is truncated to
// natural alignment and busErr stays 0.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_responder_if.slave   bus,
  output logic [1:0]            dbg_state
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [AW+1:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Access attributes. They come from the bus in IDLE, which only matters
  // for a zero-wait access. Otherwise they come from the latched copy.
  logic [AW+1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_we;
  logic [2:0]    acc_f3;
  logic          enter_resp;
  logic          is_word, is_half, misaligned, suppress;
  logic [AW-1:0] idx;
  logic [31:0]   cur_word, st_word, ld_data, lane_data;
  logic [3:0]    lane_mask;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^bus.busAddr[31:AW+2];

  // Lane selection, store merge and load extension for the current access.
  always_comb begin
    acc_addr  = (state == ST_IDLE) ? bus.busAddr[AW+1:0] : addr_q;
    acc_wdata = (state == ST_IDLE) ? bus.busWData : wdata_q;
    acc_we    = (state == ST_IDLE) ? bus.busWe : we_q;
    acc_f3    = (state == ST_IDLE) ? bus.busFunc3 : f3_q;
    enter_resp = reset && (((state == ST_IDLE) && bus.busReq && (WAIT_CYCLES == 0)) ||
                           ((state == ST_WAIT) && (cnt == 4'd0)));
    is_word    = acc_f3[1];
    is_half    = !acc_f3[1] && acc_f3[0];
    misaligned = (is_half && acc_addr[0]) || (is_word && (acc_addr[1:0] != 2'b00));
`ifdef BUS_MISALIGN_ERR_EN
    suppress = misaligned;
`else
    suppress = 1'b0;
`endif
    idx      = acc_addr[AW+1:2];
    cur_word = mem[idx];
    if (is_word) begin
      lane_mask = 4'b1111;
      lane_data = acc_wdata;
    end else if (is_half) begin
      lane_mask = acc_addr[1] ? 4'b1100 : 4'b0011;
      lane_data = {2{acc_wdata[15:0]}};
    end else begin
      lane_mask = 4'b0001 << acc_addr[1:0];
      lane_data = {4{acc_wdata[7:0]}};
    end
    st_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_mask[i]) st_word[8*i +: 8] = lane_data[8*i +: 8];
    end
    ld_byte = cur_word[8*acc_addr[1:0] +: 8];
    ld_half = acc_addr[1] ? cur_word[31:16] : cur_word[15:0];
    if (is_word)      ld_data = cur_word;
    else if (is_half) ld_data = acc_f3[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
    else              ld_data = acc_f3[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    if (suppress) ld_data = 32'b0;
  end

  // A store commits on the edge that enters RESP. Memory is never reset.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_we && !suppress) mem[idx] <= st_word;
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      if (enter_resp) begin
        ready_q <= 1'b1;
        err_q   <= suppress;
        if (!acc_we) rdata_q <= ld_data;
      end
      case (state)
        ST_IDLE: begin
          if (bus.busReq) begin
            addr_q  <= bus.busAddr[AW+1:0];
            wdata_q <= bus.busWData;
            we_q    <= bus.busWe;
            f3_q    <= bus.busFunc3;
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              cnt   <= CNT_INIT;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busRData = rdata_q;
  assign bus.busReady = ready_q;
  assign bus.busErr   = err_q;
  assign dbg_state    = state;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder. One instance runs with WAIT_CYCLES=1 and a
// second runs with WAIT_CYCLES=3. A byte-level memory model predicts every
// load value, busErr and latency.
`timescale 1ns/1ps
module tb_data_mem_responder;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, rst_b;
  logic [1:0] st_a, st_b;

  data_mem_responder_if bus_a();
  data_mem_responder_if bus_b();

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(rst_a), .bus(bus_a), .dbg_state(st_a));
  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .reset(rst_b), .bus(bus_b), .dbg_state(st_b));

`ifdef BUS_MISALIGN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]  ref_mem [2][1024];
  logic [31:0] ref_rdata [2];
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int acc_size(input logic [2:0] f3);
    return f3[1] ? 4 : (f3[0] ? 2 : 1);
  endfunction

  function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) & (acc_size(f3) - 1)) != 0;
  endfunction

  // Applies one access to the model and returns the expected rdata and err.
  function automatic void model_op(input int sel, input logic we, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   output logic [31:0] exp_rd, output logic exp_err);
    int sz = acc_size(f3);
    int base = int'(a[9:0]) & ~(sz - 1);
    logic [31:0] v = 32'b0;
    exp_err = ERR_EN && is_mis(f3, a);
    if (we) begin
      if (!exp_err) for (int i = 0; i < sz; i++) ref_mem[sel][base + i] = wd[8*i +: 8];
      exp_rd = ref_rdata[sel];
    end else begin
      if (!exp_err) begin
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[sel][base + i];
        if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
      end
      exp_rd = v;
      ref_rdata[sel] = v;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input logic req, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    if (sel == 0) begin
      bus_a.busReq = req; bus_a.busWe = we; bus_a.busFunc3 = f3;
      bus_a.busAddr = a; bus_a.busWData = wd;
    end else begin
      bus_b.busReq = req; bus_b.busWe = we; bus_b.busFunc3 = f3;
      bus_b.busAddr = a; bus_b.busWData = wd;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bus_a.busReady : bus_b.busReady;
  endfunction
  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? bus_a.busRData : bus_b.busRData;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? bus_a.busErr : bus_b.busErr;
  endfunction

  // Counts edges until busReady is seen, with a bound. lat=-1 on timeout.
  task automatic wait_ready(input int sel, input int already, output int lat);
    lat = -1;
    for (int k = already + 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (get_ready(sel)) begin
        lat = k;
        break;
      end
    end
  endtask

  // One full access. The DUT is back in IDLE when this returns.
  task automatic do_access(input int sel, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err, output int lat);
    drive(sel, 1'b1, we, f3, a, wd);
    wait_ready(sel, 0, lat);
    rd  = get_rdata(sel);
    err = get_err(sel);
    drive(sel, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  // Access plus model comparison of latency, err and rdata.
  task automatic checked_op(input string nm, input int sel, input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input int exp_lat);
    logic [31:0] rd, erd;
    logic err, eerr;
    int lat;
    model_op(sel, we, f3, a, wd, erd, eerr);
    do_access(sel, we, f3, a, wd, rd, err, lat);
    n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("FAIL %s latency got %0d want %0d", nm, lat, exp_lat); end
    n_cmp++; if (err !== eerr) begin n_bad++; $display("FAIL %s err got %b want %b", nm, err, eerr); end
    n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL %s rdata got %h want %h", nm, rd, erd); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_cmp++; if (get_rdata(s) !== 32'h0) begin n_bad++; $display("FAIL reset_rdata%0d got %h want 0", s, get_rdata(s)); end
      n_cmp++; if (get_ready(s) !== 1'b0) begin n_bad++; $display("FAIL reset_ready%0d got %b want 0", s, get_ready(s)); end
      n_cmp++; if (get_err(s) !== 1'b0) begin n_bad++; $display("FAIL reset_err%0d got %b want 0", s, get_err(s)); end
      ref_rdata[s] = 32'h0;
    end
    rst_a = 1'b1; rst_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic init_memory();
    logic [31:0] rd, erd;
    logic err, eerr;
    int lat;
    for (int w = 0; w < 256; w++) begin
      logic [31:0] v = $urandom;
      model_op(0, 1'b1, 3'b010, 32'(w * 4), v, erd, eerr);
      do_access(0, 1'b1, 3'b010, 32'(w * 4), v, rd, err, lat);
    end
    model_op(1, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, erd, eerr);
    do_access(1, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, rd, err, lat);
  endtask

  task automatic test_word();
    checked_op("sw_10", 0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2);
    checked_op("lw_10", 0, 1'b0, 3'b010, 32'h10, 32'h0, 2);
    n_cmp++; if (bus_a.busRData !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_10_const got %h want deadbeef", bus_a.busRData); end
  endtask

  task automatic test_extension();
    logic [31:0] want [4];
    logic [2:0]  f3s [4];
    logic [31:0] adrs [4];
    want = '{32'hFFFFFF80, 32'h00000080, 32'h00007F02, 32'h000080F1};
    f3s  = '{3'b000, 3'b100, 3'b001, 3'b101};
    adrs = '{32'h23, 32'h23, 32'h20, 32'h22};
    checked_op("sw_20", 0, 1'b1, 3'b010, 32'h20, 32'h80F17F02, 2);
    for (int i = 0; i < 4; i++) begin
      checked_op("ext_load", 0, 1'b0, f3s[i], adrs[i], 32'h0, 2);
      n_cmp++; if (bus_a.busRData !== want[i]) begin n_bad++; $display("FAIL ext_const%0d got %h want %h", i, bus_a.busRData, want[i]); end
    end
  endtask

  task automatic test_partial();
    checked_op("sw_30", 0, 1'b1, 3'b010, 32'h30, 32'h11223344, 2);
    checked_op("sb_31", 0, 1'b1, 3'b000, 32'h31, 32'hFFFFFFAA, 2);
    checked_op("sh_32", 0, 1'b1, 3'b001, 32'h32, 32'hFFFFBBCC, 2);
    checked_op("lw_30", 0, 1'b0, 3'b010, 32'h30, 32'h0, 2);
    n_cmp++; if (bus_a.busRData !== 32'hBBCCAA44) begin n_bad++; $display("FAIL partial_const got %h want bbccaa44", bus_a.busRData); end
  endtask

  task automatic test_wrap();
    checked_op("sw_400", 0, 1'b1, 3'b010, 32'h400, 32'h5, 2);
    checked_op("lw_0", 0, 1'b0, 3'b010, 32'h0, 32'h0, 2);
    n_cmp++; if (bus_a.busRData !== 32'h5) begin n_bad++; $display("FAIL wrap_const got %h want 5", bus_a.busRData); end
  endtask

  task automatic test_hold();
    logic [31:0] erd;
    logic eerr;
    int lat;
    model_op(0, 1'b1, 3'b010, 32'h50, 32'h11111111, erd, eerr);
    drive(0, 1'b1, 1'b1, 3'b010, 32'h50, 32'h11111111);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 3'b000, 32'h54, 32'h22222222);
    wait_ready(0, 1, lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL hold_latency got %0d want 2", lat); end
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk); #1;
    checked_op("hold_lw50", 0, 1'b0, 3'b010, 32'h50, 32'h0, 2);
    n_cmp++; if (bus_a.busRData !== 32'h11111111) begin n_bad++; $display("FAIL hold_const got %h want 11111111", bus_a.busRData); end
    checked_op("hold_lw54", 0, 1'b0, 3'b010, 32'h54, 32'h0, 2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] erd1, erd2;
    logic eerr;
    int lat;
    model_op(0, 1'b0, 3'b010, 32'h10, 32'h0, erd1, eerr);
    model_op(0, 1'b0, 3'b010, 32'h20, 32'h0, erd2, eerr);
    drive(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    wait_ready(0, 0, lat);
    n_cmp++; if (bus_a.busRData !== erd1) begin n_bad++; $display("FAIL b2b_first got %h want %h", bus_a.busRData, erd1); end
    drive(0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    @(posedge clk); #1;
    n_cmp++; if (bus_a.busReady !== 1'b0) begin n_bad++; $display("FAIL b2b_gap got %b want 0", bus_a.busReady); end
    wait_ready(0, 0, lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL b2b_latency got %0d want 2", lat); end
    n_cmp++; if (bus_a.busRData !== erd2) begin n_bad++; $display("FAIL b2b_second got %h want %h", bus_a.busRData, erd2); end
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    checked_op("w3_lw40", 1, 1'b0, 3'b010, 32'h40, 32'h0, 4);
    drive(1, 1'b1, 1'b1, 3'b010, 32'h40, 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk); #1;
    ref_rdata[1] = 32'h0;
    n_cmp++; if (bus_b.busRData !== 32'h0) begin n_bad++; $display("FAIL mid_reset_rdata got %h want 0", bus_b.busRData); end
    rst_b = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus_b.busReady) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL mid_reset_ready got %0d pulses want 0", seen); end
    checked_op("w3_lw40_after", 1, 1'b0, 3'b010, 32'h40, 32'h0, 4);
    n_cmp++; if (bus_b.busRData !== 32'hCAFEF00D) begin n_bad++; $display("FAIL mid_reset_const got %h want cafef00d", bus_b.busRData); end
  endtask

  task automatic test_misalign();
    logic [31:0] want;
    want = ERR_EN ? {ref_mem[0][32'h43], ref_mem[0][32'h42], ref_mem[0][32'h41], ref_mem[0][32'h40]}
                  : 32'h12345678;
    checked_op("sw_42", 0, 1'b1, 3'b010, 32'h42, 32'h12345678, 2);
    checked_op("lw_40", 0, 1'b0, 3'b010, 32'h40, 32'h0, 2);
    n_cmp++; if (bus_a.busRData !== want) begin n_bad++; $display("FAIL misalign_word got %h want %h", bus_a.busRData, want); end
    checked_op("lh_21", 0, 1'b0, 3'b001, 32'h21, 32'h0, 2);
    checked_op("sh_33", 0, 1'b1, 3'b101, 32'h33, 32'h0000A5A5, 2);
    checked_op("lw_30m", 0, 1'b0, 3'b010, 32'h30, 32'h0, 2);
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, got;
    logic err, eerr;
    int lat;
    for (int i = 0; i < 120; i++) begin
      logic we = 1'($urandom_range(0, 1));
      logic [2:0] f3 = 3'($urandom_range(0, 7));
      logic [31:0] a = $urandom;
      logic [31:0] wd = $urandom;
      model_op(0, we, f3, a, wd, erd, eerr);
      exp_q.push_back(erd);
      do_access(0, we, f3, a, wd, rd, err, lat);
      got = exp_q.pop_front();
      n_cmp++; if (rd !== got) begin n_bad++; $display("FAIL rand%0d rdata got %h want %h (we=%b f3=%0d a=%h)", i, rd, got, we, f3, a); end
      n_cmp++; if (err !== eerr) begin n_bad++; $display("FAIL rand%0d err got %b want %b", i, err, eerr); end
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rand%0d latency got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_reset_clears();
    checked_op("pre_reset_lw", 0, 1'b0, 3'b010, 32'h10, 32'h0, 2);
    rst_a = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus_a.busRData !== 32'h0) begin n_bad++; $display("FAIL reset_clears_rdata got %h want 0", bus_a.busRData); end
    rst_a = 1'b1;
    ref_rdata[0] = 32'h0;
    @(posedge clk); #1;
    checked_op("post_reset_lw", 0, 1'b0, 3'b010, 32'h10, 32'h0, 2);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    init_memory();
    test_word();
    test_extension();
    test_partial();
    test_wrap();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    test_random();
    test_reset_clears();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit memory words (power of two, at least 4).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning the extra wait states per access (0 to 15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port busReq, input, 1 bit: the requester holds it high until busReady.
REQ-006 SHALL have port busWe, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port busFunc3, input, 3 bits: RV32I load/store funct3 size and sign code.
REQ-008 SHALL have port busAddr, input, 32 bits: byte address.
REQ-009 SHALL have port busWData, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port busRData, output, 32 bits: load data, extended to 32 bits.
REQ-011 SHALL have port busReady, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port busErr, output, 1 bit: misaligned-access flag, valid with busReady.

Function
REQ-013 SHALL implement the FSM states IDLE, WAIT and RESP.
- IDLE with busReq=1: latch addr, we, func3 and wdata.
  - WAIT_CYCLES=0: go to RESP.
  - Otherwise: load the counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT: decrement the counter; go to RESP on the edge where the counter is 0.
- RESP: go to IDLE unconditionally.
REQ-014 SHALL assert busReady for exactly the single cycle spent in RESP; the accept-to-busReady latency is WAIT_CYCLES+1 cycles.
REQ-015 SHALL sample busReq only in IDLE; address, data, size and we changes during WAIT/RESP SHALL have no effect.
REQ-016 SHALL commit a store, and capture load data, on the edge entering RESP.
REQ-017 SHALL hold busRData from that edge until the next load completes; stores SHALL leave busRData unchanged.
REQ-018 SHALL use busFunc3 codes as follows:
- 000 = byte, signed.
- 001 = half, signed.
- 010 = word.
- 100 = byte, unsigned.
- 101 = half, unsigned.
- 011, 110, 111 = word access.
REQ-019 SHALL form the word index from busAddr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so out-of-range addresses wrap.
REQ-020 SHALL select byte lanes by address: a byte uses addr[1:0]; a half uses addr[1] (lanes 1:0 or 3:2); a word uses all lanes.
REQ-021 SHALL modify only the selected lanes on a store, taking store data from busWData[7:0] for a byte and busWData[15:0] for a half.
REQ-022 SHALL sign-extend (signed codes) or zero-extend (unsigned codes) load data from the selected lane(s).
REQ-023 SHALL treat a busReq that remains high in the IDLE cycle after RESP as a new request.

Reset
REQ-024 SHALL, while reset=0 at a clock edge, force the state to IDLE and clear busRData, busReady, busErr and the counter to 0.
REQ-025 SHALL discard an access that is in WAIT or RESP when reset is applied: no store commit and no busReady.
REQ-026 SHALL NOT clear memory contents on reset.

Configuration
REQ-027 SHALL support the macro BUS_MISALIGN_ERR_EN, where a misaligned access is a half with addr[0]=1 or a word with addr[1:0]!=0.
- Defined:
  - A misaligned store SHALL be suppressed.
  - A misaligned load SHALL return 0 in busRData.
  - busErr SHALL pulse together with busReady.
  - The timing SHALL be unchanged.
- Undefined:
  - busErr SHALL be tied to 0.
  - Misaligned addresses SHALL be truncated to natural alignment as in REQ-020.

Verification
REQ-028 Word store/load, WAIT_CYCLES=1: store 0xDEADBEEF to addr 0x10, then load from 0x10 -> busReady 2 cycles after each accept; busRData=0xDEADBEEF.
REQ-029 Byte/half extension: with 0x80F17F02 stored at 0x20:
- lb 0x23 -> 0xFFFFFF80.
- lbu 0x23 -> 0x00000080.
- lh 0x20 -> 0x00007F02.
- lhu 0x22 -> 0x000080F1.
REQ-030 Partial store: word 0x11223344 at 0x30, then sb 0xAA at 0x31, then sh 0xBBCC at 0x32 -> lw 0x30 returns 0xBBCCAA44.
REQ-031 Wrap and hold, DEPTH_WORDS=256: store 0x5 at 0x400 -> lw 0x0 returns 0x5. Changing busAddr during WAIT has no effect. A back-to-back busReq is accepted in the IDLE cycle after RESP.
REQ-032 Reset mid-access, WAIT_CYCLES=3: store 0x1 to 0x40, then reset=0 in the second WAIT cycle -> no busReady; a later lw 0x40 returns the prior contents.
REQ-033 Misalignment, sw 0x12345678 to 0x42:
- With BUS_MISALIGN_ERR_EN: busErr=1 with busReady; word 0x40 is unchanged.
- Without it: busErr=0; word 0x40 becomes 0x12345678.
